// File: rtl/pwm_shadow_ctrl.sv
// rtl/pwm_shadow_ctrl.sv - PWM generator with shadowed period/duty driving an external wrap counter
//
// Purpose:
//   Enables an external max-value wrap counter and turns its count/carry into a PWM
//   waveform. Period/duty arrive over a valid/ready config port. While running, a new
//   config is parked in a shadow register and only becomes active on a period
//   boundary (co). This keeps every period glitch-free.
//
// Ports:
//   clk          in   1   clock
//   rst_n        in   1   asynchronous active-low reset
//   run          in   1   level: 1 = generate, 0 = stop at end of current period
//   cfg_valid    in   1   config request
//   cfg_ready    out  1   config accept; the handshake is valid & ready at posedge clk
//   cfg_period   in   DW  period value; the period lasts cfg_period+1 cycles
//   cfg_duty     in   DW  number of high cycles per period
//   cnt_en       out  1   enable to the counter
//   max          out  DW  active period value, fed to the counter wrap value
//   cnt          in   DW  counter value
//   co           in   1   counter carry (en & cnt==max)
//   pwm          out  1   registered PWM output
//   period_done  out  1   registered copy of co
//   cfg_applied  out  1   1-cycle pulse after the shadow config was copied to active

module pwm_shadow_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_period,
  input  logic [DW-1:0] cfg_duty,
  output logic          cnt_en,
  output logic [DW-1:0] max,
  input  logic [DW-1:0] cnt,
  input  logic          co,
  output logic          pwm,
  output logic          period_done,
  output logic          cfg_applied
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [DW-1:0] period_act;
  logic [DW-1:0] duty_act;
  logic [DW-1:0] shadow_period;
  logic [DW-1:0] shadow_duty;
  logic          shadow_full;

  logic          accept;
  logic          apply;
  logic          idle;

  assign idle      = (state == IDLE);
  assign cfg_ready = !shadow_full;
  assign accept    = cfg_valid & cfg_ready;
  // A pending shadow is applied at a period boundary, or at once when the
  // generator has stopped (a shadow accepted on the final co lands here in IDLE).
  assign apply     = shadow_full & (co | idle);
  assign max       = period_act;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Leaving the running states only happens on co, so the
  // current period always runs to completion.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (run) state_next = RUN;
      end
      RUN: begin
        if (!run) state_next = co ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (run)     state_next = RUN;
        else if (co) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_en = 1'b0;
    if (state != IDLE) cnt_en = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Config path. accept needs an empty shadow and apply needs a full one, so the
  // two never happen in the same cycle. A handshake on the same cycle as co with
  // an empty shadow goes to the shadow and waits for the next co (no bypass).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act    <= '0;
      duty_act      <= '0;
      shadow_period <= '0;
      shadow_duty   <= '0;
      shadow_full   <= 1'b0;
      cfg_applied   <= 1'b0;
    end else begin
      cfg_applied <= apply;
      if (apply) begin
        period_act  <= shadow_period;
        duty_act    <= shadow_duty;
        shadow_full <= 1'b0;
      end else if (accept) begin
        if (idle) begin
          period_act <= cfg_period;
          duty_act   <= cfg_duty;
        end else begin
          shadow_period <= cfg_period;
          shadow_duty   <= cfg_duty;
          shadow_full   <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Waveform. An unsigned compare gives constant 0 for duty 0 and constant 1 for
  // duty above the period, with no special cases.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm         <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm         <= (state != IDLE) & (cnt < duty_act);
      period_done <= co;
    end
  end

endmodule

// File: tb/tb_pwm_shadow_ctrl.sv
// tb/tb_pwm_shadow_ctrl.sv - directed self-checking bench for pwm_shadow_ctrl with a wrap counter model
module tb_pwm_shadow_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_period = '0;
  logic [DW-1:0] cfg_duty = '0;
  logic          cnt_en;
  logic [DW-1:0] max;
  logic [DW-1:0] cnt;
  logic          co;
  logic          pwm;
  logic          period_done;
  logic          cfg_applied;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // External max-value wrap counter, reset by the same rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (cnt_en) cnt <= (cnt == max) ? '0 : cnt + 1'b1;
  end
  assign co = cnt_en & (cnt == max);

  pwm_shadow_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cnt_en(cnt_en), .max(max), .cnt(cnt), .co(co),
    .pwm(pwm), .period_done(period_done), .cfg_applied(cfg_applied)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [DW-1:0] v);
    int n = 0;
    while (cnt !== v && n < 40) begin tick(); n++; end
    checks++; if (cnt !== v) begin fails++; $display("FAIL wait_cnt got=%0d exp=%0d", cnt, v); end
  endtask

  task automatic load_running(input logic [DW-1:0] p, input logic [DW-1:0] d);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 40) begin tick(); n++; end
    cfg_valid = 1'b1; cfg_period = p; cfg_duty = d;
    tick();
    cfg_valid = 1'b0;
    n = 0;
    while (cfg_applied !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (cfg_applied !== 1'b1) begin fails++; $display("FAIL load_applied got=%0b exp=1", cfg_applied); end
    checks++; if (max !== p) begin fails++; $display("FAIL load_max got=%0d exp=%0d", max, p); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_cfg_ready got=%0b exp=1", cfg_ready); end
    checks++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL rst_cnt_en got=%0b exp=0", cnt_en); end
    checks++; if (max !== 0) begin fails++; $display("FAIL rst_max got=%0d exp=0", max); end
    checks++; if (pwm !== 1'b0) begin fails++; $display("FAIL rst_pwm got=%0b exp=0", pwm); end
    checks++; if (period_done !== 1'b0) begin fails++; $display("FAIL rst_period_done got=%0b exp=0", period_done); end
    checks++; if (cfg_applied !== 1'b0) begin fails++; $display("FAIL rst_cfg_applied got=%0b exp=0", cfg_applied); end
    rst_n = 1'b1;
    tick();
    checks++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL rst_idle_hold got=%0b exp=0", cnt_en); end
  endtask

  task automatic test_basic;
    cfg_valid = 1'b1; cfg_period = 9; cfg_duty = 3;
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got=%0b exp=1", cfg_ready); end
    tick();
    cfg_valid = 1'b0; run = 1'b1;
    checks++; if (max !== 9) begin fails++; $display("FAIL basic_direct_max got=%0d exp=9", max); end
    checks++; if (cfg_applied !== 1'b0) begin fails++; $display("FAIL basic_no_apply got=%0b exp=0", cfg_applied); end
    checks++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL basic_en_idle got=%0b exp=0", cnt_en); end
    tick();
    for (int i = 0; i < 25; i++) begin
      checks++; if (cnt !== DW'(i % 10)) begin fails++; $display("FAIL basic_cnt[%0d] got=%0d exp=%0d", i, cnt, i % 10); end
      checks++; if (pwm !== (i % 10 >= 1 && i % 10 <= 3)) begin fails++; $display("FAIL basic_pwm[%0d] got=%0b", i, pwm); end
      checks++; if (period_done !== (i > 0 && i % 10 == 0)) begin fails++; $display("FAIL basic_done[%0d] got=%0b", i, period_done); end
      checks++; if (cnt_en !== 1'b1) begin fails++; $display("FAIL basic_en[%0d] got=%0b exp=1", i, cnt_en); end
      tick();
    end
  endtask

  task automatic test_shadow_update;
    wait_cnt(4);
    cfg_valid = 1'b1; cfg_period = 4; cfg_duty = 4;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL shadow_ready_low got=%0b exp=0", cfg_ready); end
    checks++; if (max !== 9) begin fails++; $display("FAIL shadow_max_old got=%0d exp=9", max); end
    for (int c = 6; c <= 9; c++) begin
      tick();
      checks++; if (cnt !== DW'(c)) begin fails++; $display("FAIL shadow_cnt got=%0d exp=%0d", cnt, c); end
      checks++; if (max !== 9) begin fails++; $display("FAIL shadow_max_hold got=%0d exp=9", max); end
      checks++; if (pwm !== 1'b0) begin fails++; $display("FAIL shadow_old_pwm got=%0b exp=0", pwm); end
      checks++; if (cfg_applied !== 1'b0) begin fails++; $display("FAIL shadow_early_apply got=%0b exp=0", cfg_applied); end
    end
    tick();
    checks++; if (cfg_applied !== 1'b1) begin fails++; $display("FAIL shadow_apply got=%0b exp=1", cfg_applied); end
    checks++; if (max !== 4) begin fails++; $display("FAIL shadow_max_new got=%0d exp=4", max); end
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL shadow_ready_back got=%0b exp=1", cfg_ready); end
    checks++; if (period_done !== 1'b1) begin fails++; $display("FAIL shadow_done got=%0b exp=1", period_done); end
    for (int j = 1; j <= 10; j++) begin
      tick();
      checks++; if (cnt !== DW'(j % 5)) begin fails++; $display("FAIL shadow_new_cnt got=%0d exp=%0d", cnt, j % 5); end
      checks++; if (pwm !== (j % 5 != 0)) begin fails++; $display("FAIL shadow_new_pwm[%0d] got=%0b", j, pwm); end
      checks++; if (cfg_applied !== 1'b0) begin fails++; $display("FAIL shadow_pulse_len got=%0b exp=0", cfg_applied); end
    end
  endtask

  task automatic test_edge_duty;
    load_running(9, 0);
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++; if (pwm !== 1'b0) begin fails++; $display("FAIL duty0_pwm[%0d] got=%0b exp=0", j, pwm); end
    end
    load_running(9, 10);
    for (int j = 1; j <= 20; j++) begin
      tick();
      checks++; if (pwm !== 1'b1) begin fails++; $display("FAIL duty_over_pwm[%0d] got=%0b exp=1", j, pwm); end
    end
    load_running(0, 1);
    for (int j = 1; j <= 5; j++) begin
      tick();
      checks++; if (cnt !== 0) begin fails++; $display("FAIL p0_cnt got=%0d exp=0", cnt); end
      checks++; if (co !== 1'b1) begin fails++; $display("FAIL p0_co got=%0b exp=1", co); end
      checks++; if (pwm !== 1'b1) begin fails++; $display("FAIL p0_pwm got=%0b exp=1", pwm); end
      checks++; if (period_done !== 1'b1) begin fails++; $display("FAIL p0_done got=%0b exp=1", period_done); end
    end
  endtask

  task automatic test_run_stop;
    load_running(9, 3);
    wait_cnt(2);
    run = 1'b0;
    tick();
    for (int c = 3; c <= 9; c++) begin
      checks++; if (cnt !== DW'(c)) begin fails++; $display("FAIL drain_cnt got=%0d exp=%0d", cnt, c); end
      checks++; if (cnt_en !== 1'b1) begin fails++; $display("FAIL drain_en got=%0b exp=1", cnt_en); end
      if (c < 9) tick();
    end
    tick();
    checks++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL stop_en got=%0b exp=0", cnt_en); end
    checks++; if (cnt !== 0) begin fails++; $display("FAIL stop_cnt got=%0d exp=0", cnt); end
    checks++; if (period_done !== 1'b1) begin fails++; $display("FAIL stop_done got=%0b exp=1", period_done); end
    tick(); tick();
    checks++; if (cnt !== 0) begin fails++; $display("FAIL idle_cnt_hold got=%0d exp=0", cnt); end
    checks++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL idle_en got=%0b exp=0", cnt_en); end
    checks++; if (pwm !== 1'b0) begin fails++; $display("FAIL idle_pwm got=%0b exp=0", pwm); end
    run = 1'b1;
    tick();
    checks++; if (cnt_en !== 1'b1) begin fails++; $display("FAIL restart_en got=%0b exp=1", cnt_en); end
    wait_cnt(2);
    run = 1'b0;
    tick();
    run = 1'b1;
    checks++; if (cnt !== 3) begin fails++; $display("FAIL redrain_cnt got=%0d exp=3", cnt); end
    tick();
    checks++; if (cnt !== 4) begin fails++; $display("FAIL resume_cnt got=%0d exp=4", cnt); end
    for (int c = 5; c <= 14; c++) begin
      tick();
      checks++; if (cnt !== DW'(c % 10)) begin fails++; $display("FAIL resume_seq got=%0d exp=%0d", cnt, c % 10); end
      checks++; if (cnt_en !== 1'b1) begin fails++; $display("FAIL resume_en got=%0b exp=1", cnt_en); end
    end
  endtask

  task automatic test_cfg_at_co;
    wait_cnt(9);
    checks++; if (co !== 1'b1) begin fails++; $display("FAIL coinc_co got=%0b exp=1", co); end
    cfg_valid = 1'b1; cfg_period = 4; cfg_duty = 1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_applied !== 1'b0) begin fails++; $display("FAIL coinc_no_bypass got=%0b exp=0", cfg_applied); end
    checks++; if (max !== 9) begin fails++; $display("FAIL coinc_max_old got=%0d exp=9", max); end
    checks++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL coinc_ready got=%0b exp=0", cfg_ready); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (max !== 9 || cfg_applied !== 1'b0) begin fails++; $display("FAIL coinc_hold max=%0d applied=%0b exp=9/0", max, cfg_applied); end
    end
    tick();
    checks++; if (cfg_applied !== 1'b1) begin fails++; $display("FAIL coinc_apply got=%0b exp=1", cfg_applied); end
    checks++; if (max !== 4) begin fails++; $display("FAIL coinc_max_new got=%0d exp=4", max); end
  endtask

  task automatic test_reset_mid;
    wait_cnt(1);
    checks++; if (pwm !== 1'b1) begin fails++; $display("FAIL mid_pre_pwm got=%0b exp=1", pwm); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL mid_rst_en got=%0b exp=0", cnt_en); end
    checks++; if (max !== 0) begin fails++; $display("FAIL mid_rst_max got=%0d exp=0", max); end
    checks++; if (pwm !== 1'b0) begin fails++; $display("FAIL mid_rst_pwm got=%0b exp=0", pwm); end
    checks++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready got=%0b exp=1", cfg_ready); end
    checks++; if (cnt !== 0) begin fails++; $display("FAIL mid_rst_cnt got=%0d exp=0", cnt); end
    tick();
    rst_n = 1'b1;
    checks++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL mid_idle_en got=%0b exp=0", cnt_en); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (pwm !== 1'b0) begin fails++; $display("FAIL mid_duty_cleared got=%0b exp=0", pwm); end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow_update();
    test_edge_duty();
    test_run_stop();
    test_cfg_at_co();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
